// File: rtl/idu_pipe.sv
// idu_pipe: single-stage RV32I/RV64I instruction decoder with valid/ready flow control.
// Define IDU_PIPE_SKID_EN for a 2-entry (output + skid) buffer whose in_ready comes straight from a flop.
module idu_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_ctr,
    output logic [8:0]      out_ctrl,
    output logic [14:0]     out_regs
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_PASSB = 4'd2;
    localparam logic [3:0] ALU_SLL   = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_SLTU  = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_OR    = 4'd9;
    localparam logic [3:0] ALU_AND   = 4'd10;

    localparam int C_APC  = 0;
    localparam int C_BIMM = 1;
    localparam int C_RW   = 2;
    localparam int C_BR   = 3;
    localparam int C_JMP  = 4;
    localparam int C_MR   = 5;
    localparam int C_MW   = 6;
    localparam int C_ILL  = 7;
    localparam int C_WORD = 8;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu;
        logic [8:0]      ctrl;
        logic [14:0]     regs;
    } bundle_t;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_sel = ALU_SLL;
            3'd2:    alu_sel = ALU_SLT;
            3'd3:    alu_sel = ALU_SLTU;
            3'd4:    alu_sel = ALU_XOR;
            3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    assign imm_i32 = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u32 = {in_inst[31:12], 12'b0};
    assign imm_j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    assign imm_i = XLEN'(imm_i32);
    assign imm_s = XLEN'(imm_s32);
    assign imm_b = XLEN'(imm_b32);
    assign imm_u = XLEN'(imm_u32);
    assign imm_j = XLEN'(imm_j32);

    bundle_t dec;
    logic    bad;

    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        dec.regs = {in_inst[11:7], in_inst[24:20], in_inst[19:15]};
        dec.alu  = ALU_ADD;
        bad      = 1'b0;
        case (opc)
            OP_LUI: begin
                dec.imm = imm_u;
                dec.alu = ALU_PASSB;
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_RW]   = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm = imm_u;
                dec.ctrl[C_APC]  = 1'b1;
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_RW]   = 1'b1;
            end
            OP_JAL: begin
                dec.imm = imm_j;
                dec.ctrl[C_APC]  = 1'b1;
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_JMP]  = 1'b1;
                dec.ctrl[C_RW]   = 1'b1;
            end
            OP_JALR: begin
                bad = (f3 != 3'd0);
                dec.imm = imm_i;
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_JMP]  = 1'b1;
                dec.ctrl[C_RW]   = 1'b1;
            end
            OP_BRANCH: begin
                bad = (f3 == 3'd2) || (f3 == 3'd3);
                dec.imm = imm_b;
                dec.alu = ALU_SUB;
                dec.ctrl[C_BR] = 1'b1;
            end
            OP_LOAD: begin
                // ld and lwu exist only on RV64
                bad = (f3 == 3'd7) || (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
                dec.imm = imm_i;
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_MR]   = 1'b1;
                dec.ctrl[C_RW]   = 1'b1;
            end
            OP_STORE: begin
                bad = f3[2] || (!RV64 && f3 == 3'd3);
                dec.imm = imm_s;
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_MW]   = 1'b1;
            end
            OP_IMM: begin
                dec.imm = imm_i;
                dec.alu = alu_sel(f3, (f3 == 3'd5) && in_inst[30]);
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_RW]   = 1'b1;
                // shift immediates: funct6 must be clean, shamt[5] only on RV64
                if (f3 == 3'd1)
                    bad = (in_inst[31:26] != 6'd0) || (!RV64 && in_inst[25]);
                else if (f3 == 3'd5)
                    bad = ({in_inst[31], in_inst[29:26]} != 5'd0) || (!RV64 && in_inst[25]);
            end
            OP_REG: begin
                dec.alu = alu_sel(f3, f7[5]);
                dec.ctrl[C_RW] = 1'b1;
                bad = (f7 != 7'h00) && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            OP_IMM32: begin
                dec.imm = imm_i;
                dec.alu = alu_sel(f3, (f3 == 3'd5) && f7[5]);
                dec.ctrl[C_BIMM] = 1'b1;
                dec.ctrl[C_RW]   = 1'b1;
                dec.ctrl[C_WORD] = 1'b1;
                case (f3)
                    3'd0:    bad = !RV64;
                    3'd1:    bad = !RV64 || (f7 != 7'h00);
                    3'd5:    bad = !RV64 || (f7 != 7'h00 && f7 != 7'h20);
                    default: bad = 1'b1;
                endcase
            end
            OP_REG32: begin
                dec.alu = alu_sel(f3, f7[5]);
                dec.ctrl[C_RW]   = 1'b1;
                dec.ctrl[C_WORD] = 1'b1;
                case (f3)
                    3'd0, 3'd5: bad = !RV64 || (f7 != 7'h00 && f7 != 7'h20);
                    3'd1:       bad = !RV64 || (f7 != 7'h00);
                    default:    bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec.imm  = '0;
            dec.alu  = ALU_ADD;
            dec.ctrl = '0;
            dec.ctrl[C_ILL] = 1'b1;
        end
    end

    bundle_t out_q;
    logic    out_vld;
    logic    take;

    assign take        = in_valid && in_ready && !flush;
    assign out_valid   = out_vld;
    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_alu_ctr = out_q.alu;
    assign out_ctrl    = out_q.ctrl;
    assign out_regs    = out_q.regs;

`ifdef IDU_PIPE_SKID_EN
    bundle_t skid_q;
    logic    skid_empty;

    assign in_ready = skid_empty;

    // Output register plus skid; a stalled output parks the new bundle in the skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
            skid_empty <= 1'b1;
        end else if (flush) begin
            out_vld    <= 1'b0;
            skid_empty <= 1'b1;
        end else if (out_vld && !out_ready) begin
            if (take) begin
                skid_q     <= dec;
                skid_empty <= 1'b0;
            end
        end else if (!skid_empty) begin
            out_q      <= skid_q;
            out_vld    <= 1'b1;
            skid_empty <= 1'b1;
        end else begin
            out_vld <= take;
            if (take)
                out_q <= dec;
        end
    end
`else
    assign in_ready = out_ready || !out_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (in_ready) begin
            out_vld <= take;
            if (take)
                out_q <= dec;
        end
    end
`endif

endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream has an instruction.
REQ-005 in_ready  output  1  stage can accept an instruction.
REQ-006 in_inst  input  32  raw instruction.
REQ-007 in_pc  input  XLEN  instruction PC.
REQ-008 flush  input  1  discard all held and incoming instructions.
REQ-009 out_valid  output  1  decoded bundle present.
REQ-010 out_ready  input  1  downstream accepts bundle.
REQ-011 out_pc  output  XLEN  PC of the decoded instruction.
REQ-012 out_imm  output  XLEN  sign-extended immediate.
REQ-013 out_alu_ctr  output  4  ALU op: 0 add, 1 sub, 2 pass-B, 3 sll, 4 slt, 5 sltu, 6 xor, 7 srl, 8 sra, 9 or, 10 and.
REQ-014 out_ctrl  output  9  bit 0 A=pc, 1 B=imm, 2 reg_write, 3 cond_branch, 4 jump, 5 mem_read, 6 mem_write, 7 illegal, 8 word_op.
REQ-015 out_regs  output  15  {rd, rs2, rs1}, 5 bits each, copied from instruction fields.

Function
REQ-016 Decode covers RV32I/RV64I base opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, and OP-IMM-32/OP-32 when XLEN=64.
REQ-017 Immediate formats: I, S, B, J, U; bit 31 is sign-extended to XLEN; R-type and illegal instructions yield 0.
REQ-018 LUI: ALU op pass-B, B=imm, reg_write; AUIPC: add, A=pc, B=imm, reg_write; JAL: add, A=pc, B=imm, jump, reg_write; JALR: add, B=imm, jump, reg_write.
REQ-019 BRANCH: sub, cond_branch, rs1/rs2 operands; LOAD: add, B=imm, mem_read, reg_write; STORE: add, B=imm, mem_write.
REQ-020 OP/OP-IMM ALU op selected from funct3 and funct7[5]; SUB/SRA only where funct7[5]=1 is legal.
REQ-021 illegal=1, with all other ctrl bits 0, for unknown opcode, illegal funct3/funct7 combination, shamt[5]=1 when XLEN=32, or any *W opcode when XLEN=32.
REQ-022 word_op=1 for OP-IMM-32/OP-32 only.
REQ-023 Latency: an instruction accepted in cycle N appears with out_valid=1 in cycle N+1.
REQ-024 Input transfer occurs when in_valid and in_ready; output transfer occurs when out_valid and out_ready.
REQ-025 While out_valid=1 and out_ready=0, all out_* signals hold stable.
REQ-026 Accept and drain in the same cycle is a full-throughput update: the new bundle replaces the old with no bubble.
REQ-027 flush has priority: next cycle out_valid=0 and buffered entries are discarded; any input handshake in the flush cycle is dropped.
REQ-028 No instruction is duplicated or lost except by flush.

Reset
REQ-029 rst_n low immediately forces out_valid=0, out_ctrl=0, out_alu_ctr=0, out_imm=0, out_pc=0, and out_regs=0; the skid entry, when present, is emptied.
REQ-030 in_ready is 1 during the first cycle after reset release.
REQ-031 Reset asserted mid-transfer discards the in-flight instruction.

Configuration
REQ-032 Macro IDU_PIPE_SKID_EN defined: a 2-entry buffer (output register plus skid register); in_ready is driven only by a flop, equal to "skid entry empty"; a stall fills the skid, which drains first on out_ready.
REQ-033 Macro undefined: single output register; in_ready = out_ready or not out_valid (combinational path).

Verification
REQ-034 in_inst 0x12345037 (lui x0) and 0xFFFFF0B7 (lui x1), XLEN=64 -> next cycle out_imm 0xFFFFFFFFFFFFF000 for the second, alu_ctr 2, ctrl bits 1 and 2 set, rd=1.
REQ-035 jal x1,-4 (0xFFDFF0EF) with pc 0x80000010 -> out_imm 0xFFFFFFFFFFFFFFFC, ctrl A=pc, B=imm, jump, and reg_write set, out_pc 0x80000010.
REQ-036 Stream of 4 back-to-back instructions with out_ready held 0 for 3 cycles -> out_* stable, no loss; with SKID_EN, in_ready falls one cycle after the stall begins.
REQ-037 Opcode 0x7F and XLEN=32 addw -> illegal=1, reg_write=0.
REQ-038 flush asserted together with in_valid while the skid is full -> next cycle out_valid=0 and in_ready=1; the following accepted instruction is the next one emitted.
REQ-039 rst_n pulsed low mid-stream -> outputs zero asynchronously; first post-reset instruction emerges with 1-cycle latency.
